// File: rtl/irq_ctrl.sv
// Interrupt controller: rising-edge capture into a pending register,
// masking, fixed-priority selection (index 0 highest) and a
// request / in-service handshake with the CPU. Software acknowledges
// completion by writing STAT (EOI).
`timescale 1ns/1ps
module irq_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [29:0]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             int_ack,
  output logic             int_req,
  output logic [3:0]       int_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    INSV = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [N_SRC-1:0] irq_q_reg;
  logic [N_SRC-1:0] pend_reg, pend_next;
  logic [N_SRC-1:0] mask_reg;
  logic             en_reg;
  logic             int_req_reg, int_req_next;
  logic [3:0]       int_id_reg, int_id_next;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [15:0]      elig_ext;
  logic [N_SRC-1:0] w1c_clr;
  logic [N_SRC-1:0] ack_clr;
  logic [3:0]       sel;
  logic             wr_pend, wr_mask, wr_ctrl, eoi;
  logic             ack_take;
  logic             insv;
  logic             unused_bits;

  // Only Addr[1:0] (byte address bits 3:2) select a register; the rest of
  // the address and the write data above the register width are don't-care.
  assign unused_bits = ^{Addr[29:2], Din[31:N_SRC]};

  assign wr_pend = WE && (Addr[1:0] == 2'd0);
  assign wr_mask = WE && (Addr[1:0] == 2'd1);
  assign wr_ctrl = WE && (Addr[1:0] == 2'd2);
  assign eoi     = WE && (Addr[1:0] == 2'd3) && (state_reg == INSV);

  assign insv     = (state_reg == INSV);
  assign rise     = irq_in & ~irq_q_reg;
  assign eligible = pend_reg & mask_reg;
  assign elig_ext = 16'(eligible);
  assign ack_take = (state_reg == REQ) && int_ack;
  assign w1c_clr  = wr_pend ? Din[N_SRC-1:0] : '0;
  assign ack_clr  = ack_take ? (N_SRC'(1) << int_id_reg) : '0;

  // Per-bit pending update: a new edge always wins over a clear.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_pend
      assign pend_next[gi] = rise[gi] | (pend_reg[gi] & ~w1c_clr[gi] & ~ack_clr[gi]);
    end
  endgenerate

  // Priority encoder: scan downward so the lowest eligible index ends up selected.
  always_comb begin
    sel = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = 4'(i);
    end
  end

  // Next-state and request/ID logic for the request handshake.
  always_comb begin
    state_next   = state_reg;
    int_req_next = int_req_reg;
    int_id_next  = int_id_reg;
    case (state_reg)
      IDLE: begin
        if (en_reg && (|eligible)) begin
          int_id_next  = sel;
          int_req_next = 1'b1;
          state_next   = REQ;
        end
      end
      REQ: begin
        // Acknowledge takes precedence over a simultaneous withdraw.
        if (int_ack) begin
          int_req_next = 1'b0;
          state_next   = INSV;
        end else if (!en_reg || !elig_ext[int_id_reg]) begin
          int_req_next = 1'b0;
          state_next   = IDLE;
        end
      end
      INSV: begin
        int_req_next = 1'b0;
        if (eoi) state_next = IDLE;
      end
      default: begin
        int_req_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  // State, edge-detect and software-visible registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      irq_q_reg   <= '0;
      pend_reg    <= '0;
      mask_reg    <= '0;
      en_reg      <= 1'b0;
      int_req_reg <= 1'b0;
      int_id_reg  <= 4'd0;
    end else begin
      state_reg   <= state_next;
      irq_q_reg   <= irq_in;
      pend_reg    <= pend_next;
      int_req_reg <= int_req_next;
      int_id_reg  <= int_id_next;
      if (wr_mask) mask_reg <= Din[N_SRC-1:0];
      if (wr_ctrl) en_reg   <= Din[0];
    end
  end

  // Combinational read mux over the four-word register window.
  always_comb begin
    Dout = 32'd0;
    case (Addr[1:0])
      2'd0: Dout = 32'(pend_reg);
      2'd1: Dout = 32'(mask_reg);
      2'd2: Dout = {31'd0, en_reg};
      2'd3: Dout = {27'd0, insv, int_id_reg};
      default: Dout = 32'd0;
    endcase
  end

  assign int_req = int_req_reg;
  assign int_id  = int_id_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: cycle-by-cycle vectors whose expected
// outputs go through a scoreboard queue and are compared after each edge.
`timescale 1ns/1ps
module tb_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [5:0]  irq_in;
  logic        int_ack;
  logic        int_req;
  logic [3:0]  int_id;

  irq_ctrl #(.N_SRC(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .irq_in  (irq_in),
    .int_ack (int_ack),
    .int_req (int_req),
    .int_id  (int_id)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [5:0]  irq;
    logic        ack;
    logic        exp_req;
    logic [3:0]  exp_id;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[19];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input int r, input int a, input int w, input int d,
                              input int irq, input int ack,
                              input int req, input int id, input int dout);
    vec_t v;
    v.rst      = 1'(r);
    v.addr     = 2'(a);
    v.we       = 1'(w);
    v.din      = 32'(d);
    v.irq      = 6'(irq);
    v.ack      = 1'(ack);
    v.exp_req  = 1'(req);
    v.exp_id   = 4'(id);
    v.exp_dout = 32'(dout);
    return v;
  endfunction

  task automatic check(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h required %h", tag, what, act, exp);
    end
  endtask

  // Drive one vector on the falling edge, then compare after the rising edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    rst     = v.rst;
    Addr    = {28'd0, v.addr};
    WE      = v.we;
    Din     = v.din;
    irq_in  = v.irq;
    int_ack = v.ack;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(tag, "int_req", {31'd0, int_req}, {31'd0, e.exp_req});
    check(tag, "int_id",  {28'd0, int_id},  {28'd0, e.exp_id});
    check(tag, "Dout",    Dout,             e.exp_dout);
    $display("%s addr=%0d we=%0d din=%h irq=%h ack=%0d -> req=%0d id=%0d dout=%h",
             tag, v.addr, v.we, v.din, v.irq, v.ack, int_req, int_id, Dout);
  endtask

  initial begin
    rst = 1'b1; Addr = '0; WE = 1'b0; Din = '0; irq_in = '0; int_ack = 1'b0;

    // Reset, configure, single source; then two simultaneous sources.
    //          rst a we din    irq   ack req id dout
    tbl[0]  = mk(1, 0, 0, 0,    0,    0,  0, 0, 0);
    tbl[1]  = mk(1, 3, 0, 0,    0,    0,  0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 'h3F, 0,    0,  0, 0, 'h3F);
    tbl[3]  = mk(0, 2, 1, 1,    0,    0,  0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0,    0,    0,  0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,    'h04, 0,  0, 0, 'h04);
    tbl[6]  = mk(0, 0, 0, 0,    'h04, 0,  1, 2, 'h04);
    tbl[7]  = mk(0, 0, 0, 0,    'h04, 1,  0, 2, 0);
    tbl[8]  = mk(0, 3, 0, 0,    'h04, 0,  0, 2, 'h12);
    tbl[9]  = mk(0, 3, 1, 0,    'h04, 0,  0, 2, 'h02);
    tbl[10] = mk(0, 0, 0, 0,    0,    0,  0, 2, 0);
    tbl[11] = mk(0, 0, 0, 0,    'h12, 0,  0, 2, 'h12);
    tbl[12] = mk(0, 0, 0, 0,    'h12, 0,  1, 1, 'h12);
    tbl[13] = mk(0, 0, 0, 0,    'h12, 1,  0, 1, 'h10);
    tbl[14] = mk(0, 3, 1, 0,    'h12, 0,  0, 1, 'h01);
    tbl[15] = mk(0, 0, 0, 0,    'h12, 0,  1, 4, 'h10);
    tbl[16] = mk(0, 0, 0, 0,    'h12, 1,  0, 4, 0);
    tbl[17] = mk(0, 3, 1, 0,    'h12, 0,  0, 4, 'h04);
    tbl[18] = mk(0, 0, 0, 0,    0,    0,  0, 4, 0);
    for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Masking the active request withdraws it; pending is kept; unmask re-requests.
    apply(mk(0, 0, 0, 0,    8, 0, 0, 4, 8),    "mask_s0");
    apply(mk(0, 0, 0, 0,    8, 0, 1, 3, 8),    "mask_s1");
    apply(mk(0, 1, 1, 'h37, 8, 0, 1, 3, 'h37), "mask_s2");
    apply(mk(0, 0, 0, 0,    8, 0, 0, 3, 8),    "mask_s3");
    apply(mk(0, 0, 0, 0,    8, 0, 0, 3, 8),    "mask_s4");
    apply(mk(0, 1, 1, 'h3F, 8, 0, 0, 3, 'h3F), "mask_s5");
    apply(mk(0, 0, 0, 0,    8, 0, 1, 3, 8),    "mask_s6");
    apply(mk(0, 0, 0, 0,    8, 1, 0, 3, 0),    "mask_s7");
    apply(mk(0, 3, 1, 0,    8, 0, 0, 3, 3),    "mask_s8");
    apply(mk(0, 0, 0, 0,    0, 0, 0, 3, 0),    "mask_s9");

    // W1C coinciding with a new rise on the same bit: the set wins.
    apply(mk(0, 2, 1, 0, 0, 0, 0, 3, 0), "w1c_u0");
    apply(mk(0, 0, 0, 0, 1, 0, 0, 3, 1), "w1c_u1");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 3, 1), "w1c_u2");
    apply(mk(0, 0, 1, 1, 1, 0, 0, 3, 1), "w1c_u3");
    apply(mk(0, 0, 1, 1, 1, 0, 0, 3, 0), "w1c_u4");

    // Level held high: one edge only; with EN=0 no request is raised.
    for (int i = 0; i < 10; i++) apply(mk(0, 0, 0, 0, 'h20, 0, 0, 3, 'h20), $sformatf("hold[%0d]", i));
    apply(mk(0, 0, 1, 'h20, 'h20, 0, 0, 3, 0), "hold_clr");
    apply(mk(0, 0, 0, 0,    'h20, 0, 0, 3, 0), "hold_after0");
    apply(mk(0, 0, 0, 0,    'h20, 0, 0, 3, 0), "hold_after1");
    apply(mk(0, 0, 0, 0,    0,    0, 0, 3, 0), "hold_release");

    // Reset while in service clears everything.
    apply(mk(0, 2, 1, 1, 0,    0, 0, 3, 1),    "rst_x0");
    apply(mk(0, 0, 0, 0, 4,    0, 0, 3, 4),    "rst_x1");
    apply(mk(0, 0, 0, 0, 4,    0, 1, 2, 4),    "rst_x2");
    apply(mk(0, 0, 0, 0, 4,    1, 0, 2, 0),    "rst_x3");
    apply(mk(0, 3, 0, 0, 'h0C, 0, 0, 2, 'h12), "rst_x4");
    apply(mk(0, 0, 0, 0, 'h0C, 0, 0, 2, 'h08), "rst_x5");
    apply(mk(1, 3, 0, 0, 'h0C, 0, 0, 0, 0),    "rst_x6");
    apply(mk(0, 0, 0, 0, 0,    0, 0, 0, 0),    "rst_x7");
    apply(mk(0, 1, 0, 0, 0,    0, 0, 0, 0),    "rst_x8");
    apply(mk(0, 2, 0, 0, 0,    0, 0, 0, 0),    "rst_x9");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
